// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared constants for the APB3 initiator and the benches that drive the
// SyncFIFO APB slave with it.
//   - One-hot FSM state encodings for apb_master.
//   - SyncFIFO register map: the write-data register and the status register.
//   - SyncFIFO status codes returned by a read of the status register.
// ---------------------------------------------------------------------------
package apb_pkg;

  // One-hot state encodings; any other value is treated as illegal.
  localparam logic [2:0] IDLE   = 3'b001;
  localparam logic [2:0] SETUP  = 3'b010;
  localparam logic [2:0] ACCESS = 3'b100;

  // SyncFIFO register map: base address plus per-register offsets.
  localparam logic [31:0] FIFO_BASE_ADDR  = 32'h2000_0000;
  localparam logic [31:0] FIFO_WRITE_DATA = 32'h0000_0000;
  localparam logic [31:0] FIFO_STATUS     = 32'h0000_0004;

  // Fill-level codes reported by the SyncFIFO status register.
  typedef enum logic [2:0] {
    FIFO_ST_EMPTY        = 3'd0,
    FIFO_ST_ALMOST_EMPTY = 3'd1,
    FIFO_ST_BELOW_HALF   = 3'd2,
    FIFO_ST_ABOVE_HALF   = 3'd3,
    FIFO_ST_ALMOST_FULL  = 3'd4,
    FIFO_ST_FULL         = 3'd5
  } fifo_status_e;

  // Absolute address of a SyncFIFO register, given its offset.
  function automatic logic [31:0] fifo_reg_addr(input logic [31:0] offset);
    return FIFO_BASE_ADDR + offset;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// ---------------------------------------------------------------------------
// apb_master_if
// Bundles the command stream, the response stream and the APB3 bus of
// apb_master.
//   master modport : the initiator (apb_master) side.
//   slave modport  : the environment side (command source, response sink
//                    and APB completer).
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command stream
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout          : response pulse
//   psel/penable/pwrite/paddr/pwdata                 : APB requests
//   prdata/pready/pslverr                            : APB completions
// ---------------------------------------------------------------------------
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  prdata, pready, pslverr,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output prdata, pready, pslverr,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB3 initiator. It turns a valid/ready command stream into APB3 read/write
// transfers and returns one single-cycle response per transfer. It handles
// slave wait states, back-to-back transfers (2 cycles per zero-wait transfer)
// and PSLVERR.
// Ports:
//   clk  : clock, all logic on its rising edge
//   rst  : asynchronous active-high reset
//   bus  : apb_master_if.master (command, response and APB signals)
// Build option:
//   APB_TIMEOUT_EN : when defined, a watchdog aborts a transfer after
//                    TIMEOUT_CYCLES ACCESS cycles with PREADY low and reports
//                    rsp_err=1, rsp_timeout=1. Otherwise ACCESS waits
//                    indefinitely and rsp_timeout is always 0.
// ---------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic         clk,
  input logic         rst,
  apb_master_if.master bus
);

  logic [2:0]        state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic       rsp_timeout_q, rsp_timeout_d;
  logic [7:0] wdog_q, wdog_d;
`else
  // The watchdog length has no meaning without the watchdog.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
      wdog_q        <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
      wdog_q        <= wdog_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
    wdog_d        = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          state_d  = SETUP;
`ifdef APB_TIMEOUT_EN
          wdog_d   = 8'd0;
`endif
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_valid_d = 1'b1;
          if (!pwrite_q) begin
            rsp_rdata_d = bus.prdata;
          end
          rsp_err_d = bus.pslverr;
`ifdef APB_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          // cmd_ready follows pready here, so a waiting command is taken now
          // and the bus goes straight back to SETUP without dropping psel.
          if (bus.cmd_valid) begin
            pwrite_d = bus.cmd_write;
            paddr_d  = bus.cmd_addr;
            pwdata_d = bus.cmd_wdata;
            state_d  = SETUP;
`ifdef APB_TIMEOUT_EN
            wdog_d   = 8'd0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          // Abort: no command can be taken here because pready is low.
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d  = IDLE;
        pwrite_d = 1'b0;
        paddr_d  = '0;
        pwdata_d = '0;
      end
    endcase
  end

  // Output decode: psel/penable come straight from the state; an illegal
  // state forces every APB output low.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    bus.pwrite    = 1'b0;
    bus.paddr     = '0;
    bus.pwdata    = '0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.pwrite    = pwrite_q;
        bus.paddr     = paddr_q;
        bus.pwdata    = pwdata_q;
      end
      SETUP: begin
        bus.psel   = 1'b1;
        bus.pwrite = pwrite_q;
        bus.paddr  = paddr_q;
        bus.pwdata = pwdata_q;
      end
      ACCESS: begin
        bus.cmd_ready = bus.pready;
        bus.psel      = 1'b1;
        bus.penable   = 1'b1;
        bus.pwrite    = pwrite_q;
        bus.paddr     = paddr_q;
        bus.pwdata    = pwdata_q;
      end
      default: ;
    endcase
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
// Directed and randomized bench for apb_master. Commands are issued by the
// stimulus block; a completer model answers with a per-transfer wait count,
// read data and error flag; a monitor follows the outstanding transfers in a
// queue and checks the bus and every response against them.
// ---------------------------------------------------------------------------
module tb_apb_master;
  import apb_pkg::*;

  localparam int TMO = 16;
`ifdef APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    int          cyc;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  txn_t        acc_q[$];
  txn_t        slv_q[$];
  txn_t        cur;
  logic [31:0] model_rdata = 32'h0;
  int          cyc = 0;
  int          front_cycles = 0;
  int          rsp_count = 0;
  int          rsp_cyc_prev = 0;
  int          rsp_cyc_last = 0;

  // Completer model: response values are presented only in the completing
  // cycle; other cycles carry random noise on prdata/pslverr.
  txn_t scfg;
  int   acc_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      slv_q.delete();
      acc_cnt     = 0;
      bus.pready  = 1'b0;
      bus.prdata  = 32'h0;
      bus.pslverr = 1'b0;
    end else if (bus.psel && bus.penable) begin
      if (acc_cnt == 0) begin
        if (slv_q.size() > 0) scfg = slv_q.pop_front();
        else begin
          scfg.waits = 0; scfg.rdata = 32'h0; scfg.err = 1'b0;
        end
      end
      bus.pready  = (acc_cnt == scfg.waits);
      bus.prdata  = bus.pready ? scfg.rdata : $urandom;
      bus.pslverr = bus.pready ? scfg.err : 1'($urandom_range(0, 1));
      acc_cnt++;
    end else begin
      acc_cnt     = 0;
      bus.pready  = 1'b0;
      bus.prdata  = $urandom;
      bus.pslverr = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: responses, bus state of the oldest outstanding transfer, and
  // command acceptance, in that order within each sample point.
  always @(negedge clk) begin
    txn_t        t;
    logic [31:0] exp_rd;
    bit          aborted;
    cyc++;
    if (rst) begin
      acc_q.delete();
      front_cycles = 0;
      model_rdata  = 32'h0;
    end else begin
      if (bus.rsp_valid) begin
        rsp_count++;
        rsp_cyc_prev = rsp_cyc_last;
        rsp_cyc_last = cyc;
        if (acc_q.size() == 0) begin
          check("unexpected_rsp", {31'h0, bus.rsp_valid}, 32'h0);
        end else begin
          t = acc_q.pop_front();
          front_cycles = 0;
          aborted = TMO_EN && (t.waits >= TMO);
          exp_rd  = (aborted || t.w) ? model_rdata : t.rdata;
          model_rdata = exp_rd;
          check("rsp_rdata", bus.rsp_rdata, exp_rd);
          check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, aborted ? 1'b1 : t.err});
          check("rsp_timeout", {31'h0, bus.rsp_timeout}, {31'h0, aborted});
          check("rsp_latency", cyc - t.cyc, aborted ? 2 + TMO : 3 + t.waits);
          $display("rsp %0d: %s addr=%h wdata=%h waits=%0d -> rdata=%h err=%0b to=%0b lat=%0d",
                   rsp_count, t.w ? "WR" : "RD", t.addr, t.wdata, t.waits,
                   bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, cyc - t.cyc);
        end
      end
      if (acc_q.size() > 0) begin
        t = acc_q[0];
        check("psel_busy", {31'h0, bus.psel}, 32'h1);
        check("penable", {31'h0, bus.penable}, (front_cycles > 0) ? 32'h1 : 32'h0);
        check("pwrite", {31'h0, bus.pwrite}, {31'h0, t.w});
        check("paddr", bus.paddr, t.addr);
        check("pwdata", bus.pwdata, t.wdata);
        check("cmd_ready_busy", {31'h0, bus.cmd_ready},
              (front_cycles == 0) ? 32'h0 : {31'h0, bus.pready});
        front_cycles++;
      end else begin
        check("psel_idle", {31'h0, bus.psel}, 32'h0);
        check("penable_idle", {31'h0, bus.penable}, 32'h0);
        check("cmd_ready_idle", {31'h0, bus.cmd_ready}, 32'h1);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        t = cur;
        t.cyc = cyc;
        acc_q.push_back(t);
        slv_q.push_back(t);
      end
    end
  end

  // Present one command and return just after the edge that accepts it.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input logic [31:0] rd, input logic err);
    int n;
    cur.w = w; cur.addr = a; cur.wdata = d; cur.waits = waits;
    cur.rdata = rd; cur.err = err; cur.cyc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) break;
    end
    check("accept_wait", {31'h0, n < 100}, 32'h1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 2000; n++) begin
      if (acc_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain", {31'h0, n < 2000}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int snap;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    cur.w = 1'b0; cur.addr = 32'h0; cur.wdata = 32'h0;
    cur.rdata = 32'h0; cur.waits = 0; cur.err = 1'b0; cur.cyc = 0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psel", {31'h0, bus.psel}, 32'h0);
    check("rst_penable", {31'h0, bus.penable}, 32'h0);
    check("rst_pwrite", {31'h0, bus.pwrite}, 32'h0);
    check("rst_paddr", bus.paddr, 32'h0);
    check("rst_pwdata", bus.pwdata, 32'h0);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    check("rst_rsp_timeout", {31'h0, bus.rsp_timeout}, 32'h0);
    check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle for 20 cycles: no response may appear.
    repeat (20) begin @(posedge clk); #1; end
    check("idle_no_rsp", rsp_count, 0);

    // Zero-wait write to the FIFO data register.
    send(1'b1, fifo_reg_addr(FIFO_WRITE_DATA), 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    drain();
    check("wr_err", {31'h0, bus.rsp_err}, 32'h0);

    // Status read with 3 wait states, FIFO full.
    send(1'b0, fifo_reg_addr(FIFO_STATUS), 32'h0, 3, 32'(FIFO_ST_FULL), 1'b0);
    drain();
    check("status_rdata", bus.rsp_rdata, 32'h0000_0005);

    // Back-to-back writes.
    send(1'b1, FIFO_BASE_ADDR, 32'h11, 0, 32'h0, 1'b0);
    send(1'b1, FIFO_BASE_ADDR, 32'h22, 0, 32'h0, 1'b0);
    drain();
    check("b2b_gap", rsp_cyc_last - rsp_cyc_prev, 2);

    // Slave error.
    send(1'b1, 32'h3000_0000, 32'hA5A5_0001, 0, 32'h0, 1'b1);
    drain();
    check("slverr_err", {31'h0, bus.rsp_err}, 32'h1);
    check("slverr_timeout", {31'h0, bus.rsp_timeout}, 32'h0);

`ifdef APB_TIMEOUT_EN
    // Stuck completer: abort, then a normal transfer.
    send(1'b1, FIFO_BASE_ADDR, 32'h0000_0BAD, 1000, 32'h0, 1'b0);
    drain();
    check("tmo_flag", {31'h0, bus.rsp_timeout}, 32'h1);
    send(1'b1, FIFO_BASE_ADDR, 32'h33, 0, 32'h0, 1'b0);
    drain();
    check("tmo_recover", {31'h0, bus.rsp_timeout}, 32'h0);
`endif

    // Randomized traffic with random wait states, errors and idle gaps.
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), $urandom, $urandom, int'($urandom_range(0, 4)),
           $urandom, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    // Reset in the middle of a transfer: bus drops at once, no response.
    send(1'b0, fifo_reg_addr(FIFO_STATUS), 32'h0, 5, 32'h1234_5678, 1'b0);
    @(posedge clk); #3;
    snap = rsp_count;
    rst = 1'b1;
    #1;
    check("midrst_psel", {31'h0, bus.psel}, 32'h0);
    check("midrst_penable", {31'h0, bus.penable}, 32'h0);
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("midrst_no_rsp", rsp_count, snap);
    check("midrst_rdata", bus.rsp_rdata, 32'h0);

    // A transfer after the reset still works.
    send(1'b0, fifo_reg_addr(FIFO_STATUS), 32'h0, 1, 32'(FIFO_ST_EMPTY), 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
